// File: rtl/mlp_layer_seq_pkg.sv
// Shared FSM encoding and width helper for the sequential MLP layer blocks.
// Pure declarations: no latency, no flow control.
package mlp_layer_seq_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_LAST  = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  // Index width that never collapses to zero bits for single-entry ranges.
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/mlp_layer_seq_requant.sv
// Accumulator -> DW requantisation: arithmetic shift by FRAC, optional clamp, optional ReLU.
// Combinational, zero latency; no flow control.
module mlp_layer_seq_requant #(
  parameter int DW    = 16,
  parameter int FRAC  = 15,
  parameter int ACC_W = 40,
  parameter int RELU  = 1,
  parameter int SAT   = 1
) (
  input  logic signed [ACC_W-1:0] acc_i,
  output logic signed [DW-1:0]    res_o
);

  localparam logic signed [ACC_W-1:0] MAXV = {{(ACC_W-DW+1){1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] MINV = {{(ACC_W-DW+1){1'b1}}, {(DW-1){1'b0}}};

  logic signed [ACC_W-1:0] shifted;
  logic signed [DW-1:0]    val;

  always_comb begin
    shifted = acc_i >>> FRAC;
    val     = shifted[DW-1:0];
    if (SAT != 0) begin
      if (shifted > MAXV)      val = MAXV[DW-1:0];
      else if (shifted < MINV) val = MINV[DW-1:0];
    end
    res_o = ((RELU != 0) && val[DW-1]) ? '0 : val;
  end

endmodule

// File: rtl/mlp_layer_seq.sv
// Fully-connected layer on one shared MAC, weights/bias streamed from a 1-cycle synchronous ROM, running argmax.
// Latency N_OUT*(N_IN+2)+1 cycles from start to done; start is ignored unless idle.
module mlp_layer_seq
  import mlp_layer_seq_pkg::*;
#(
  parameter int N_IN  = 8,
  parameter int N_OUT = 4,
  parameter int DW    = 16,
  parameter int FRAC  = 15,
  parameter int ACC_W = 40,
  parameter int RELU  = 1,
  parameter int SAT   = 1
) (
  input  logic                                         clk,
  input  logic                                         rst_n,
  input  logic                                         start,
  input  logic [N_IN*DW-1:0]                           in_vec,
  output logic                                         busy,
  output logic                                         done,
  output logic [N_OUT*DW-1:0]                          out_vec,
  output logic [clog2_min1(N_OUT)-1:0]                 class_idx,
  output logic [clog2_min1(N_OUT*(N_IN+1))-1:0]        rom_addr,
  output logic                                         rom_en,
  input  logic [DW-1:0]                                rom_rdata
);

  localparam int AW = clog2_min1(N_OUT*(N_IN+1));
  localparam int KW = clog2_min1(N_IN+1);
  localparam int JW = clog2_min1(N_OUT);
  localparam logic [KW-1:0] K_LAST = KW'(N_IN);
  localparam logic [JW-1:0] J_LAST = JW'(N_OUT-1);

  state_e                  state_q;
  logic [KW-1:0]           k_q, kd_q;
  logic [JW-1:0]           j_q;
  logic [AW-1:0]           addr_q;
  logic                    rom_en_q, vld_q, busy_q, done_q;
  logic signed [DW-1:0]    x_q [N_IN];
  logic signed [ACC_W-1:0] acc_q, acc_base, acc_sum, term;
  logic signed [DW-1:0]    xsel, wdat, res, best_val_q, best_val_d;
  logic signed [2*DW-1:0]  prod;
  logic [JW-1:0]           best_idx_q, best_idx_d, class_q;
  logic [N_OUT*DW-1:0]     shadow_q, shadow_d, out_vec_q;

  // kd_q is the k of the word arriving this cycle; k==0 restarts the sum, k==N_IN is the bias.
  always_comb begin
    wdat = $signed(rom_rdata);
    xsel = '0;
    for (int i = 0; i < N_IN; i++) begin
      if (kd_q == KW'(i)) xsel = x_q[i];
    end
    prod     = xsel * wdat;
    term     = (kd_q == K_LAST) ? (ACC_W'(wdat) <<< FRAC) : ACC_W'(prod);
    acc_base = (kd_q == '0) ? '0 : acc_q;
    acc_sum  = acc_base + term;

    shadow_d                 = shadow_q;
    shadow_d[j_q*DW +: DW]   = res;
    best_val_d               = best_val_q;
    best_idx_d               = best_idx_q;
    if ((j_q == '0) || (res > best_val_q)) begin
      best_val_d = res;
      best_idx_d = j_q;
    end
  end

  mlp_layer_seq_requant #(
    .DW(DW), .FRAC(FRAC), .ACC_W(ACC_W), .RELU(RELU), .SAT(SAT)
  ) u_requant (
    .acc_i (acc_sum),
    .res_o (res)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      k_q        <= '0;
      kd_q       <= '0;
      j_q        <= '0;
      addr_q     <= '0;
      rom_en_q   <= 1'b0;
      vld_q      <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      acc_q      <= '0;
      best_val_q <= '0;
      best_idx_q <= '0;
      class_q    <= '0;
      shadow_q   <= '0;
      out_vec_q  <= '0;
      for (int i = 0; i < N_IN; i++) x_q[i] <= '0;
    end else begin
      vld_q <= rom_en_q;
      kd_q  <= k_q;
      if (vld_q) acc_q <= acc_sum;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_q  <= S_ISSUE;
            busy_q   <= 1'b1;
            rom_en_q <= 1'b1;
            k_q      <= '0;
            j_q      <= '0;
            addr_q   <= '0;
            for (int i = 0; i < N_IN; i++) x_q[i] <= $signed(in_vec[i*DW +: DW]);
          end
        end
        S_ISSUE: begin
          if (k_q == K_LAST) begin
            state_q  <= S_LAST;
            rom_en_q <= 1'b0;
            if (j_q != J_LAST) addr_q <= addr_q + 1'b1;
          end else begin
            k_q    <= k_q + 1'b1;
            addr_q <= addr_q + 1'b1;
          end
        end
        S_LAST: begin
          shadow_q   <= shadow_d;
          best_val_q <= best_val_d;
          best_idx_q <= best_idx_d;
          if (j_q == J_LAST) begin
            state_q   <= S_DONE;
            done_q    <= 1'b1;
            out_vec_q <= shadow_d;
            class_q   <= best_idx_d;
          end else begin
            state_q  <= S_ISSUE;
            j_q      <= j_q + 1'b1;
            k_q      <= '0;
            rom_en_q <= 1'b1;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign rom_en    = rom_en_q;
  assign rom_addr  = addr_q;
  assign out_vec   = out_vec_q;
  assign class_idx = class_q;

endmodule
